// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift-register family (serializer and friends).
//   - shift_state_e   : two-state FSM encoding (ST_IDLE=0, ST_SHIFT=1)
//   - SHIFT_DEFAULT_WIDTH / SHIFT_MIN_WIDTH : common word-width constants
//   - shift_cnt_width : width of a remaining-bit counter that must hold 0..width
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  localparam int SHIFT_DEFAULT_WIDTH = 8;
  localparam int SHIFT_MIN_WIDTH     = 2;

  // The counter is loaded with the full width, so it needs width+1 codes.
  function automatic int shift_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// -----------------------------------------------------------------------------
// serializer_hold_buf
// One-entry valid/ready holding register that queues the next parallel word
// while the serializer is still shifting the current one. Only compiled when
// SERIALIZER_HOLD_BUF_EN is defined; otherwise this file contributes nothing.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset (empties the buffer)
//   in_valid_i   in   in_data_i is offered for storage
//   in_ready_o   out  buffer is empty and can take a word
//   in_data_i    in   WIDTH-bit word to store
//   out_valid_o  out  buffer holds a word
//   out_ready_i  in   consumer takes the held word this cycle
//   out_data_o   out  held word
// -----------------------------------------------------------------------------
`ifdef SERIALIZER_HOLD_BUF_EN
module serializer_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready only when empty, so a push and a pop never coincide.
  assign in_ready_o  = !full_q;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid_i && in_ready_o) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (full_q && out_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule
`endif

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
// Parallel-to-serial converter, MSB first, with a consumer-paced advance.
// Optional feature macro: SERIALIZER_HOLD_BUF_EN adds a one-word holding
// buffer so back-to-back words stream without an idle gap.
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_ni        in   asynchronous active-low reset
//   data_i        in   WIDTH-bit word to serialize
//   load_valid_i  in   data_i is valid for loading
//   load_ready_o  out  a word can be accepted this cycle
//   advance_i     in   consumer has taken the current bit_o
//   bit_o         out  current serial bit (0 when idle)
//   busy_o        out  a word is being shifted out
//   done_o        out  one-cycle pulse after the last bit of a word is taken
// -----------------------------------------------------------------------------
module serializer
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             advance_i,
  output logic             bit_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = shift_cnt_width(WIDTH);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic adv;       // advance that actually consumes a bit
  logic last_adv;  // advance that consumes the final bit of the word
  logic load_acc;  // handshake completes this cycle

  assign adv      = (state_q == ST_SHIFT) && advance_i;
  assign last_adv = adv && (cnt_q == CW'(1));
  assign load_acc = load_valid_i && load_ready_o;

`ifdef SERIALIZER_HOLD_BUF_EN
  logic             hold_in_valid;
  logic             hold_in_ready;
  logic             hold_out_valid;
  logic [WIDTH-1:0] hold_data;

  // While shifting, an offered word goes to the buffer -- except on the
  // last-bit cycle, where it bypasses straight into the shift register.
  assign hold_in_valid = load_valid_i && (state_q == ST_SHIFT) && !last_adv;
  assign load_ready_o  = hold_in_ready;

  serializer_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (hold_in_valid),
    .in_ready_o  (hold_in_ready),
    .in_data_i   (data_i),
    .out_valid_o (hold_out_valid),
    .out_ready_i (last_adv),
    .out_data_o  (hold_data)
  );
`else
  assign load_ready_o = (state_q == ST_IDLE);
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = last_adv;
    case (state_q)
      ST_IDLE: begin
        if (load_acc) begin
          state_d = ST_SHIFT;
          shreg_d = data_i;
          cnt_d   = CW'(WIDTH);
        end
      end
      ST_SHIFT: begin
        if (adv) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
`ifdef SERIALIZER_HOLD_BUF_EN
            // Chain the next word without leaving SHIFT. A held word wins;
            // when the buffer is empty its ready is high, so a concurrent
            // load is accepted and taken directly.
            if (hold_out_valid) begin
              state_d = ST_SHIFT;
              shreg_d = hold_data;
              cnt_d   = CW'(WIDTH);
            end else if (load_valid_i) begin
              state_d = ST_SHIFT;
              shreg_d = data_i;
              cnt_d   = CW'(WIDTH);
            end
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign bit_o  = busy_o && shreg_q[WIDTH-1];
  assign done_o = done_q;

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
// Self-checking bench for serializer (WIDTH=8). Table-driven words plus
// hand-written sequences for idle advance, mid-word reset and back-to-back
// loading. Expected bits are pushed to a scoreboard queue when a word is
// loaded and popped as each bit is consumed. Adapts to SERIALIZER_HOLD_BUF_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serializer;

  localparam int WIDTH = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             load_valid_i = 1'b0;
  logic             advance_i = 1'b0;
  logic             load_ready_o;
  logic             bit_o;
  logic             busy_o;
  logic             done_o;

  serializer #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .advance_i    (advance_i),
    .bit_o        (bit_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic exp_q[$];

  always @(negedge clk_i) if (done_o) done_cnt++;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               period;
    logic [WIDTH-1:0] exp_bits;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_bits(input logic [WIDTH-1:0] bits);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic run_word(input vec_t v);
    int start_done;
    check("ready_before_load", load_ready_o, 1);
    data_i       = v.data;
    load_valid_i = 1'b1;
    push_bits(v.exp_bits);
    start_done = done_cnt;
    step();
    load_valid_i = 1'b0;
    data_i       = WIDTH'($urandom_range(0, 255));
    for (int b = 0; b < WIDTH; b++) begin
      for (int p = 1; p < v.period; p++) begin
        check("bit_hold", bit_o, exp_q[0]);
        check("busy_hold", busy_o, 1);
        step();
      end
      check("bit", bit_o, exp_q.pop_front());
      check("busy", busy_o, 1);
      check("done_mid", done_o, 0);
      advance_i = 1'b1;
      step();
      advance_i = 1'b0;
    end
    check("done_pulse", done_o, 1);
    check("busy_after", busy_o, 0);
    check("bit_idle", bit_o, 0);
    step();
    check("done_once", done_o, 0);
    check("done_count", done_cnt - start_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_done;

    vecs[0] = '{8'hA5, 1, 8'b1010_0101};
    vecs[1] = '{8'h81, 3, 8'b1000_0001};
    vecs[2] = '{8'h5A, 2, 8'b0101_1010};
    vecs[3] = '{8'h01, 1, 8'b0000_0001};

    // Reset state
    step();
    step();
    check("rst_bit", bit_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ready", load_ready_o, 1);
    #2 rst_ni = 1'b1;
    step();
    check("post_rst_ready", load_ready_o, 1);
    check("post_rst_busy", busy_o, 0);

    // Table-driven words
    for (int i = 0; i < 4; i++) run_word(vecs[i]);

    // Advance toggling while idle is ignored
    start_done = done_cnt;
    for (int i = 0; i < 5; i++) begin
      advance_i = ~advance_i;
      step();
      check("idle_adv_bit", bit_o, 0);
      check("idle_adv_busy", busy_o, 0);
      check("idle_adv_done", done_o, 0);
    end
    advance_i = 1'b0;
    check("idle_adv_no_done", done_cnt - start_done, 0);

    // Mid-word asynchronous reset
    start_done   = done_cnt;
    data_i       = 8'hFF;
    load_valid_i = 1'b1;
    step();
    load_valid_i = 1'b0;
    advance_i    = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_bit", bit_o, 1);
    check("pre_rst_busy", busy_o, 1);
    #3 rst_ni = 1'b0;
    #1;
    check("async_rst_bit", bit_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_done", done_o, 0);
    check("async_rst_ready", load_ready_o, 1);
    advance_i = 1'b0;
    step();
    step();
    #3 rst_ni = 1'b1;
    step();
    check("rel_ready", load_ready_o, 1);
    check("rel_busy", busy_o, 0);
    step();
    check("rel_done", done_o, 0);
    check("rst_no_done", done_cnt - start_done, 0);
    exp_q.delete();

`ifndef SERIALIZER_HOLD_BUF_EN
    // Continuous load_valid_i: second word waits one idle cycle
    start_done   = done_cnt;
    data_i       = 8'h3C;
    load_valid_i = 1'b1;
    check("b2b_ready0", load_ready_o, 1);
    push_bits(8'b0011_1100);
    step();
    data_i    = 8'hC3;
    advance_i = 1'b1;
    for (int b = 0; b < WIDTH; b++) begin
      check("b2b_w0_bit", bit_o, exp_q.pop_front());
      check("b2b_w0_ready", load_ready_o, 0);
      check("b2b_w0_busy", busy_o, 1);
      step();
    end
    advance_i = 1'b0;
    check("b2b_gap_busy", busy_o, 0);
    check("b2b_gap_ready", load_ready_o, 1);
    check("b2b_gap_done", done_o, 1);
    push_bits(8'b1100_0011);
    step();
    load_valid_i = 1'b0;
    advance_i    = 1'b1;
    for (int b = 0; b < WIDTH; b++) begin
      check("b2b_w1_bit", bit_o, exp_q.pop_front());
      check("b2b_w1_busy", busy_o, 1);
      check("b2b_w1_ready", load_ready_o, 0);
      step();
    end
    advance_i = 1'b0;
    check("b2b_end_done", done_o, 1);
    check("b2b_end_busy", busy_o, 0);
    step();
    check("b2b_done_count", done_cnt - start_done, 2);
`else
    // Holding buffer: two words stream as 16 contiguous bits
    start_done   = done_cnt;
    data_i       = 8'h3C;
    load_valid_i = 1'b1;
    check("hb_ready0", load_ready_o, 1);
    push_bits(8'b0011_1100);
    step();
    data_i    = 8'hC3;
    advance_i = 1'b1;
    check("hb_ready_shift", load_ready_o, 1);
    check("hb_bit", bit_o, exp_q.pop_front());
    step();
    push_bits(8'b1100_0011);
    load_valid_i = 1'b0;
    data_i       = 8'h00;
    check("hb_ready_full", load_ready_o, 0);
    for (int b = 1; b < 2 * WIDTH; b++) begin
      check("hb_bit", bit_o, exp_q.pop_front());
      check("hb_busy", busy_o, 1);
      step();
    end
    advance_i = 1'b0;
    check("hb_end_done", done_o, 1);
    check("hb_end_busy", busy_o, 0);
    step();
    check("hb_done_count", done_cnt - start_done, 2);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
